// File: rtl/sbrb_pulse_driver_if.sv
// Signal bundle between the SbRb pulse driver and its command/latch side.
// The slave modport is the driver's view; master is the requester/latch view.
interface sbrb_pulse_driver_if;
  logic set_req;
  logic reset_req;
  logic clr_err;
  logic q_fb;
  logic Sb;
  logic Rb;
  logic busy;
  logic done;
  logic q_exp;
  logic conflict;
  logic err;

  modport slave (
    input  set_req, reset_req, clr_err, q_fb,
    output Sb, Rb, busy, done, q_exp, conflict, err
  );

  modport master (
    output set_req, reset_req, clr_err, q_fb,
    input  Sb, Rb, busy, done, q_exp, conflict, err
  );
endinterface

// File: rtl/sbrb_pulse_driver.sv
// Drives the active-low Sb/Rb inputs of an SbRb latch with fixed-width pulses,
// a recovery gap, and a check of the synchronized Q against the expected state.
module sbrb_pulse_driver #(
  parameter int unsigned PULSE_W = 4,
  parameter int unsigned GAP_W   = 2,
  parameter int unsigned CW      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  sbrb_pulse_driver_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SET_P, RST_P, GAP} state_t;

  state_t          r_state, w_nxt_state;
  logic [CW-1:0]   r_cnt, w_nxt_cnt;
  logic            r_sb, w_nxt_sb;
  logic            r_rb, w_nxt_rb;
  logic            r_busy, w_nxt_busy;
  logic            r_done, w_nxt_done;
  logic            r_q_exp, w_nxt_q_exp;
  logic            r_conflict, w_nxt_conflict;
  logic            r_err, w_nxt_err;
  logic            r_q_meta, r_q_s;

  // Two-flop synchronizer for the asynchronous latch output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_meta <= 1'b0;
      r_q_s    <= 1'b0;
    end else begin
      r_q_meta <= bus.q_fb;
      r_q_s    <= r_q_meta;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_sb       <= 1'b1;
      r_rb       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_q_exp    <= 1'b0;
      r_conflict <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_cnt      <= w_nxt_cnt;
      r_sb       <= w_nxt_sb;
      r_rb       <= w_nxt_rb;
      r_busy     <= w_nxt_busy;
      r_done     <= w_nxt_done;
      r_q_exp    <= w_nxt_q_exp;
      r_conflict <= w_nxt_conflict;
      r_err      <= w_nxt_err;
    end
  end

  // Next state and next output values; Sb and Rb are only ever lowered in
  // mutually exclusive states, so they cannot be low together.
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_cnt      = r_cnt;
    w_nxt_sb       = 1'b1;
    w_nxt_rb       = 1'b1;
    w_nxt_busy     = 1'b0;
    w_nxt_done     = 1'b0;
    w_nxt_q_exp    = r_q_exp;
    w_nxt_conflict = 1'b0;
    w_nxt_err      = bus.clr_err ? 1'b0 : r_err;

    case (r_state)
      IDLE: begin
        if (bus.set_req && !bus.reset_req) begin
          w_nxt_state = SET_P;
          w_nxt_sb    = 1'b0;
          w_nxt_busy  = 1'b1;
          w_nxt_cnt   = CW'(PULSE_W - 1);
        end else if (bus.reset_req && !bus.set_req) begin
          w_nxt_state = RST_P;
          w_nxt_rb    = 1'b0;
          w_nxt_busy  = 1'b1;
          w_nxt_cnt   = CW'(PULSE_W - 1);
        end else if (bus.set_req && bus.reset_req) begin
          w_nxt_conflict = 1'b1;
        end
      end
      SET_P, RST_P: begin
        w_nxt_busy = 1'b1;
        if (r_cnt == '0) begin
          w_nxt_state = GAP;
          w_nxt_cnt   = CW'(GAP_W - 1);
          w_nxt_q_exp = (r_state == SET_P);
        end else begin
          w_nxt_cnt = r_cnt - CW'(1);
          w_nxt_sb  = (r_state != SET_P);
          w_nxt_rb  = (r_state != RST_P);
        end
      end
      GAP: begin
        if (r_cnt == '0) begin
          w_nxt_state = IDLE;
          w_nxt_done  = 1'b1;
          if (r_q_s != r_q_exp) w_nxt_err = 1'b1;
        end else begin
          w_nxt_busy = 1'b1;
          w_nxt_cnt  = r_cnt - CW'(1);
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  assign bus.Sb       = r_sb;
  assign bus.Rb       = r_rb;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.q_exp    = r_q_exp;
  assign bus.conflict = r_conflict;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_sbrb_pulse_driver.sv
// Directed bench for sbrb_pulse_driver with a behavioural SbRb latch on q_fb.
module tb_sbrb_pulse_driver;

  logic clk;
  logic rst_n;
  logic latch_q;
  logic hold_q0;
  int   checks;
  int   errors;

  sbrb_pulse_driver_if u_if ();

  sbrb_pulse_driver #(.PULSE_W(4), .GAP_W(2), .CW(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Latch model; hold_q0 forces a stuck-low Q to provoke a mismatch
  initial latch_q = 1'b0;
  always @(u_if.Sb, u_if.Rb) begin
    if (u_if.Sb === 1'b0) latch_q = 1'b1;
    else if (u_if.Rb === 1'b0) latch_q = 1'b0;
  end
  assign u_if.q_fb = hold_q0 ? 1'b0 : latch_q;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input bit is_set);
    if (is_set) u_if.set_req = 1'b1;
    else        u_if.reset_req = 1'b1;
    tick();
    u_if.set_req   = 1'b0;
    u_if.reset_req = 1'b0;
  endtask

  // Checks cycles 1..7 of a command (cycle 1 = first pulse cycle); returns in the done cycle
  task automatic check_cmd(input bit is_set, input bit prev_q, input bit prev_err,
                           input bit exp_err, input bit clr_last, input bit inject_set);
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("c%0d_sb", c), u_if.Sb, (is_set && c <= 4) ? 1'b0 : 1'b1);
      chk($sformatf("c%0d_rb", c), u_if.Rb, (!is_set && c <= 4) ? 1'b0 : 1'b1);
      chk($sformatf("c%0d_not_both_low", c), u_if.Sb | u_if.Rb, 1'b1);
      chk($sformatf("c%0d_busy", c), u_if.busy, (c <= 6) ? 1'b1 : 1'b0);
      chk($sformatf("c%0d_done", c), u_if.done, (c == 7) ? 1'b1 : 1'b0);
      chk($sformatf("c%0d_q_exp", c), u_if.q_exp, (c >= 5) ? is_set : prev_q);
      chk($sformatf("c%0d_err", c), u_if.err, (c == 7) ? exp_err : prev_err);
      if (c < 7) begin
        if (inject_set && (c == 2 || c == 5)) u_if.set_req = 1'b1;
        if (clr_last && c == 6) u_if.clr_err = 1'b1;
        tick();
        u_if.set_req = 1'b0;
        u_if.clr_err = 1'b0;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    hold_q0 = 1'b0;
    u_if.set_req = 1'b0;
    u_if.reset_req = 1'b0;
    u_if.clr_err = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_sb", u_if.Sb, 1'b1);
    chk("rst_rb", u_if.Rb, 1'b1);
    chk("rst_busy", u_if.busy, 1'b0);
    chk("rst_done", u_if.done, 1'b0);
    chk("rst_q_exp", u_if.q_exp, 1'b0);
    chk("rst_conflict", u_if.conflict, 1'b0);
    chk("rst_err", u_if.err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single set, then back-to-back reset accepted in the done cycle
    issue(1'b1);
    check_cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(1'b0);
    check_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("idle_done_low", u_if.done, 1'b0);

    // Simultaneous requests
    u_if.set_req = 1'b1;
    u_if.reset_req = 1'b1;
    tick();
    u_if.set_req = 1'b0;
    u_if.reset_req = 1'b0;
    chk("conf_pulse", u_if.conflict, 1'b1);
    chk("conf_sb", u_if.Sb, 1'b1);
    chk("conf_rb", u_if.Rb, 1'b1);
    chk("conf_busy", u_if.busy, 1'b0);
    chk("conf_q_exp", u_if.q_exp, 1'b0);
    tick();
    chk("conf_one_cycle", u_if.conflict, 1'b0);
    chk("conf_still_idle", u_if.busy, 1'b0);

    // Q stuck low during set -> err; sticky through a good command; then cleared
    hold_q0 = 1'b1;
    issue(1'b1);
    check_cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    hold_q0 = 1'b0;
    issue(1'b0);
    check_cmd(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    u_if.clr_err = 1'b1;
    tick();
    u_if.clr_err = 1'b0;
    chk("clr_err", u_if.err, 1'b0);

    // Mismatch and clr_err on the same edge: set wins
    hold_q0 = 1'b1;
    issue(1'b1);
    check_cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    hold_q0 = 1'b0;

    // Asynchronous reset in the middle of a set pulse
    issue(1'b1);
    tick();
    chk("mid_sb_low", u_if.Sb, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sb", u_if.Sb, 1'b1);
    chk("mid_rst_rb", u_if.Rb, 1'b1);
    chk("mid_rst_busy", u_if.busy, 1'b0);
    chk("mid_rst_q_exp", u_if.q_exp, 1'b0);
    chk("mid_rst_err", u_if.err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("abandon_done_%0d", i), u_if.done, 1'b0);
      chk($sformatf("abandon_sb_%0d", i), u_if.Sb, 1'b1);
    end

    // set_req during RST_P and GAP is dropped
    issue(1'b0);
    check_cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("drop_sb_%0d", i), u_if.Sb, 1'b1);
      chk($sformatf("drop_busy_%0d", i), u_if.busy, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sbrb_pulse_driver.md
Name: sbrb_pulse_driver

Overview:
Clocked front-end that drives the active-low set/reset inputs (Sb, Rb) of the gate-level SbRb latch.
- Converts single-cycle set/reset requests into clean low pulses of fixed width, followed by a recovery gap.
- Guarantees Sb and Rb are never low together, which is the forbidden latch input.
- Tracks the expected latch state and checks it against the synchronized latch Q output.

Parameters:
PULSE_W, 4, cycles Sb or Rb is held low per command (legal range >= 1)
GAP_W, 2, cycles both outputs are held high after a pulse before the Q check (legal range >= 2, to cover the synchronizer latency)
CW, 4, internal counter width; must satisfy 2^CW > max(PULSE_W, GAP_W)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
set_req  in  1  request to set the latch; sampled only in IDLE
reset_req  in  1  request to reset the latch; sampled only in IDLE
clr_err  in  1  synchronous clear of err
q_fb  in  1  latch Q output, asynchronous to clk
Sb  out  1  active-low set, to latch
Rb  out  1  active-low reset, to latch
busy  out  1  command in progress
done  out  1  one-cycle pulse when a command completes
q_exp  out  1  expected latch state
conflict  out  1  one-cycle pulse: both requests seen in the same cycle
err  out  1  sticky flag: Q mismatch at check time

Behaviour:
- Reset: asynchronous and active-low. While rst_n=0, every output takes its reset value immediately, independent of clk:
  - Sb=1, Rb=1, busy=0, done=0, q_exp=0, conflict=0, err=0
  - FSM=IDLE, counter=0, synchronizer flops=0
- Registering: all outputs are registered; there are no combinational paths from inputs to outputs.
- q_fb synchronizer: 2-flop; its output is q_s.
- FSM states: IDLE, SET_P, RST_P, GAP.
- IDLE (Sb=1, Rb=1, busy=0):
  - set_req=1, reset_req=0 -> SET_P. From the next cycle: Sb=0, busy=1, counter loads PULSE_W-1.
  - reset_req=1, set_req=0 -> RST_P. From the next cycle: Rb=0, busy=1.
  - Both requests =1 -> conflict=1 for the next cycle only. No pulse is issued, state stays IDLE, q_exp is unchanged.
- SET_P / RST_P:
  - Pulse output stays low for exactly PULSE_W cycles while the counter decrements.
  - At count 0 -> GAP. Pulse output returns to 1 and the counter loads GAP_W-1.
  - q_exp updates to 1 (SET_P) or 0 (RST_P) on the first cycle of GAP.
- GAP:
  - Sb=1, Rb=1, busy=1 for exactly GAP_W cycles.
  - On the last GAP cycle, q_s is compared with q_exp. On mismatch, err is set from the next cycle.
  - Then -> IDLE, with done=1 on the first IDLE cycle.
- Back-to-back commands: a request present in the same cycle that done=1 is accepted.
- Requests during busy (SET_P, RST_P, GAP) are ignored and dropped; they are neither queued nor flagged.
- Invariants:
  - Sb=0 and Rb=0 never occur in the same cycle.
  - There is always at least GAP_W high cycles between consecutive pulses.
- err:
  - Sticky; cleared by clr_err=1 at the next clock edge.
  - If clr_err and a new mismatch occur in the same cycle, set wins and err stays 1.
- Command latency: request-cycle edge to the first low pulse cycle = 1 clock. Total command length = 1 + PULSE_W + GAP_W cycles, including done.
- Reset mid-command: Sb and Rb return to 1 asynchronously, the FSM returns to IDLE, and the command is abandoned with no done.

Test Plan:
1. Assert rst_n=0 at any time, including mid-pulse -> Sb=1, Rb=1, busy=0, err=0, q_exp=0 immediately, without waiting for a clk edge.
2. Single-cycle set_req with q_fb following the latch -> Sb=0 for exactly 4 cycles, starting 1 cycle after the request; Rb=1 throughout; busy=1 for 6 cycles; q_exp=1; done pulses once on cycle 7; err=0.
3. set then reset_req asserted in the done cycle -> Rb pulses low for 4 cycles with no idle gap beyond GAP_W; q_exp=0; Sb and Rb never low together.
4. set_req=reset_req=1 for one cycle in IDLE -> conflict=1 for one cycle; Sb=Rb=1; busy stays 0; q_exp unchanged.
5. Hold q_fb=0 during a set command -> err=1 after the check; err remains 1 through a later correct command; clr_err for one cycle -> err=0.
6. Pulse set_req during RST_P and GAP -> request ignored; exactly one Rb pulse; no Sb pulse follows.
